// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter with optional even parity
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             sdo_first,
    output logic             busy
);
    localparam int N  = WIDTH + PARITY_EN;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    shreg;
    logic [N-1:0]    frame;
    logic            accept;
    logic            last_bit;

    assign last_bit = (state == SHIFT) && (cnt == LAST);
    assign accept   = load_valid && load_ready;

    // Frame laid out in transmit order: bit 0 leaves first, parity (if any) last.
    always_comb begin
        frame = '0;
        for (int i = 0; i < WIDTH; i++) begin
            frame[i] = (MSB_FIRST != 0) ? load_data[WIDTH-1-i] : load_data[i];
        end
        if (PARITY_EN != 0) begin
            frame[N-1] = ^load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last_bit && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state == IDLE) || (cnt == LAST);
        busy       = (state == SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            shreg     <= '0;
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            sdo_first <= 1'b0;
        end else if (accept) begin
            cnt       <= '0;
            shreg     <= frame >> 1;
            sdo       <= frame[0];
            sdo_valid <= 1'b1;
            sdo_first <= 1'b1;
        end else if (state == SHIFT) begin
            if (last_bit) begin
                cnt       <= '0;
                shreg     <= '0;
                sdo       <= 1'b0;
                sdo_valid <= 1'b0;
                sdo_first <= 1'b0;
            end else begin
                cnt       <= cnt + CW'(1);
                shreg     <= shreg >> 1;
                sdo       <= shreg[0];
                sdo_first <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - randomized bench for piso_tx against a frame-queue model
module tb_piso_tx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] lv;
    logic [7:0] ld [3];
    logic [2:0] rdy, val, so, fst, bsy;

    // Three configurations: MSB-first, LSB-first, MSB-first with parity.
    int msb [3] = '{1, 0, 1};
    int par [3] = '{0, 0, 1};

    logic [1:0]  q [3][$];
    logic [2:0]  acc;
    logic [31:0] cap [3];
    int          vcnt [3];
    int          fcnt [3];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[0]), .load_data(ld[0]),
        .load_ready(rdy[0]), .sdo(so[0]), .sdo_valid(val[0]), .sdo_first(fst[0]), .busy(bsy[0]));
    piso_tx #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0)) u_d1 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[1]), .load_data(ld[1]),
        .load_ready(rdy[1]), .sdo(so[1]), .sdo_valid(val[1]), .sdo_first(fst[1]), .busy(bsy[1]));
    piso_tx #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[2]), .load_data(ld[2]),
        .load_ready(rdy[2]), .sdo(so[2]), .sdo_valid(val[2]), .sdo_first(fst[2]), .busy(bsy[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic push_frame(input int d, input logic [7:0] w);
        logic b;
        for (int i = 0; i < 8; i++) begin
            b = (msb[d] != 0) ? w[7-i] : w[i];
            q[d].push_back({b, (i == 0) ? 1'b1 : 1'b0});
        end
        if (par[d] != 0) q[d].push_back({^w, 1'b0});
    endtask

    // Model: the frame queue front is the bit on the wire; ready while <=1 bit remains.
    task automatic model_update();
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                q[d].delete();
                acc[d] = 1'b0;
            end else begin
                acc[d] = lv[d] && (q[d].size() <= 1);
                if (q[d].size() > 0) void'(q[d].pop_front());
                if (acc[d]) push_frame(d, ld[d]);
            end
        end
    endtask

    task automatic check_all();
        logic [4:0] exp;
        for (int d = 0; d < 3; d++) begin
            if (q[d].size() == 0) exp = 5'b10000;
            else exp = {(q[d].size() <= 1), 1'b1, q[d][0][1], q[d][0][0], 1'b1};
            chk($sformatf("out_d%0d", d), {27'd0, rdy[d], val[d], so[d], fst[d], bsy[d]}, {27'd0, exp});
            if (val[d]) begin
                cap[d] = {cap[d][30:0], so[d]};
                vcnt[d]++;
                if (fst[d]) fcnt[d]++;
            end
        end
    endtask

    task automatic clear_caps();
        for (int d = 0; d < 3; d++) begin
            cap[d] = '0; vcnt[d] = 0; fcnt[d] = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        lv    = 3'b111;
        acc   = '0;
        for (int d = 0; d < 3; d++) ld[d] = 8'h5A;
        clear_caps();
        // Edges with rst_n low must not accept even with load_valid high.
        @(negedge clk); check_all();
        @(posedge clk); model_update();
        @(negedge clk); check_all();
        rst_n = 1'b1;
        lv    = '0;
        cyc();

        clear_caps();
        lv = 3'b111; ld[0] = 8'hA5; ld[1] = 8'h01; ld[2] = 8'h07;
        cyc();
        lv = '0;
        for (int i = 0; i < 11; i++) cyc();
        chk("a5_msb", cap[0][7:0], 32'hA5);
        chk("a5_len", vcnt[0], 8);
        chk("a5_first", fcnt[0], 1);
        chk("01_lsb", cap[1][7:0], 32'h80);
        chk("07_par", cap[2][8:0], 32'h00F);
        chk("07_len", vcnt[2], 9);

        clear_caps();
        lv[0] = 1'b1; ld[0] = 8'hFF;
        lv[2] = 1'b1; ld[2] = 8'h03;
        cyc();
        chk("acc_ff", acc[0], 1);
        lv[2] = 1'b0;
        ld[0] = 8'h00;
        k = 0;
        do begin
            cyc();
            k++;
        end while (!acc[0] && k < 20);
        chk("acc_00", acc[0], 1);
        lv[0] = 1'b0;
        for (int i = 0; i < 12; i++) cyc();
        chk("b2b_len", vcnt[0], 16);
        chk("b2b_bits", cap[0][15:0], 32'hFF00);
        chk("b2b_first", fcnt[0], 2);
        chk("03_par", cap[2][8:0], 32'h006);

        lv[0] = 1'b1; ld[0] = 8'hC3;
        cyc();
        lv[0] = 1'b0;
        cyc(); cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", {27'd0, rdy[0], val[0], so[0], fst[0], bsy[0]}, 32'b10000);
        chk("rst_vec", {29'd0, val | so | fst | bsy}, 32'd0);
        for (int d = 0; d < 3; d++) q[d].delete();
        lv = 3'b111;
        @(posedge clk); model_update();
        #1 rst_n = 1'b1;
        lv = '0;
        @(negedge clk); check_all();

        clear_caps();
        lv[0] = 1'b1; ld[0] = 8'h3C;
        cyc();
        lv[0] = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        chk("post_rst", cap[0][7:0], 32'h3C);
        chk("post_len", vcnt[0], 8);

        for (int i = 0; i < 2000; i++) begin
            for (int d = 0; d < 3; d++) begin
                lv[d] = ($urandom_range(0, 9) < 6);
                ld[d] = 8'($urandom);
            end
            cyc();
        end
        lv = '0;
        for (int i = 0; i < 12; i++) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
